// File: rtl/eca_pkg.sv
// Shared types and constants for the elementary cellular automaton VGA renderer.
package eca_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } eca_state_t;

   localparam logic [7:0] DEFAULT_RULE  = 8'd30;
   localparam logic [5:0] DEFAULT_COLOR = 6'b111111;

   // Index of the single live cell in the seed row.
   function automatic int seed_idx(input int grid_w);
      return grid_w / 2;
   endfunction

endpackage

// File: rtl/eca_next_gen.sv
// Combinational one-generation step of a 1-D elementary cellular automaton.
// WRAP=1 gives a toroidal row, WRAP=0 reads out-of-range neighbours as 0.
module eca_next_gen #(
   parameter int GRID_W = 150,
   parameter bit WRAP   = 1'b0
) (
   input  logic [GRID_W-1:0] row_in,
   input  logic [7:0]        rule,
   output logic [GRID_W-1:0] row_out
);

   // ext[i+1] holds row_in[i]; ext[0] and ext[GRID_W+1] are the edge neighbours.
   logic [GRID_W+1:0] ext;
   logic              left_edge;
   logic              right_edge;

   assign left_edge  = WRAP ? row_in[GRID_W-1] : 1'b0;
   assign right_edge = WRAP ? row_in[0]        : 1'b0;
   assign ext        = {right_edge, row_in, left_edge};

   for (genvar i = 0; i < GRID_W; i++) begin : g_cell
      assign row_out[i] = rule[{ext[i], ext[i+1], ext[i+2]}];
   end

endmodule

// File: rtl/eca_vga_renderer.sv
// Draws successive ECA generations as stacked cell rows, scrolling one row per frame.
// Define ECA_WRAP_EN for a toroidal row boundary; otherwise edges read as dead cells.
module eca_vga_renderer
   import eca_pkg::*;
#(
   parameter int GRID_W    = 150,
   parameter int CELL_LOG2 = 2,
   parameter int H_VIS     = 640,
   parameter int V_VIS     = 480,
   parameter int V_LAST    = 524
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] hpos,
   input  logic [9:0] vpos,
   input  logic       display_on,
   input  logic [7:0] rule,
   input  logic [5:0] color,
   input  logic       reseed,
   output logic [5:0] rgb,
   output logic       seeding
);

`ifdef ECA_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   localparam int         GRID_PIX  = GRID_W << CELL_LOG2;
   localparam int         PAD       = (H_VIS - GRID_PIX) / 2;
   localparam int         IDX_W     = $clog2(GRID_W);
   localparam logic [9:0] CELL_MASK = 10'((1 << CELL_LOG2) - 1);
   localparam logic [GRID_W-1:0] SEED_ROW =
      {{(GRID_W-1){1'b0}}, 1'b1} << seed_idx(GRID_W);

   eca_state_t        state_q;
   logic              seeding_q;
   logic [GRID_W-1:0] cur_row_q;
   logic [GRID_W-1:0] save_row_q;
   logic [7:0]        rule_q;
   logic [5:0]        color_q;
   logic              reseed_pend_q;
   logic [GRID_W-1:0] gen_d;

   logic [9:0]        x;
   logic [IDX_W-1:0]  cell_idx;
   logic              in_grid;
   logic              frame_start;
   logic              row_step;
   logic              first_row;
   logic              do_seed;

   eca_next_gen #(
      .GRID_W (GRID_W),
      .WRAP   (WRAP)
   ) u_next_gen (
      .row_in  (cur_row_q),
      .rule    (rule_q),
      .row_out (gen_d)
   );

   // Wrapping subtraction makes hpos < PAD land far beyond the grid width.
   assign x        = hpos - 10'(PAD);
   assign cell_idx = IDX_W'(x >> CELL_LOG2);
   assign in_grid  = display_on && (x < 10'(GRID_PIX));

   // Both events fire on the first hblank cycle, so a visible line never sees a partial row.
   assign frame_start = (hpos == 10'(H_VIS)) && (vpos == 10'(V_LAST));
   assign row_step    = (hpos == 10'(H_VIS)) && (vpos < 10'(V_VIS)) &&
                        ((vpos & CELL_MASK) == CELL_MASK);
   assign first_row   = (vpos == CELL_MASK);
   assign do_seed     = (state_q == INIT) || reseed_pend_q || reseed;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= INIT;
         seeding_q     <= 1'b1;
         cur_row_q     <= '0;
         save_row_q    <= '0;
         rule_q        <= DEFAULT_RULE;
         color_q       <= DEFAULT_COLOR;
         reseed_pend_q <= 1'b0;
      end else if (frame_start) begin
         rule_q  <= rule;
         color_q <= color;
         if (do_seed) begin
            cur_row_q     <= SEED_ROW;
            save_row_q    <= SEED_ROW;
            state_q       <= RUN;
            seeding_q     <= 1'b1;
            reseed_pend_q <= 1'b0;
         end else begin
            cur_row_q <= save_row_q;
            seeding_q <= 1'b0;
         end
      end else begin
         if (row_step) begin
            cur_row_q <= gen_d;
            // Generation 1 of this frame becomes generation 0 of the next.
            if (first_row) begin
               save_row_q <= gen_d;
            end
         end
         if (reseed) begin
            reseed_pend_q <= 1'b1;
         end
      end
   end

   always_comb begin
      rgb = '0;
      if (in_grid && cur_row_q[cell_idx]) begin
         rgb = color_q;
      end
   end

   assign seeding = seeding_q;

endmodule
